fwd_hazard_unit: RTL and testbench

Parametrised successor to the ID-stage forwarding unit. Resolves operand sources for NREAD register read ports against STAGES in-flight writeback stages, with a fixed priority of nearest stage first. Adds a load-use stall, an r0 forwarding guard, and a sequential scoreboard for one long-latency multiply/divide (MDU) result. Sits in ID, driving the operand-mux selects and the pipeline stall line.

---
 rtl/fwd_hazard_unit.sv | 136 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// ID-stage operand forwarding and hazard detection with a single-entry MDU result scoreboard.
// Optional FWD_HAZARD_STAT_EN adds stall statistic counters (stat_lu_cnt, stat_mdu_cnt, stat_clr).
module fwd_hazard_unit #(
  parameter int unsigned NREAD   = 2,
  parameter int unsigned STAGES  = 3,
  parameter int unsigned MDU_LAT = 4,
  localparam int unsigned SELW   = $clog2(STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [NREAD*5-1:0]      id_rd_addr,
  input  logic [NREAD-1:0]        id_rd_used,
  input  logic                    id_is_mdu,
  input  logic [STAGES-1:0]       stage_regwr,
  input  logic [STAGES*5-1:0]     stage_regdst,
  input  logic                    ex_is_load,
  input  logic                    mdu_start,
  input  logic [4:0]              mdu_dst,
`ifdef FWD_HAZARD_STAT_EN
  input  logic                    stat_clr,
  output logic [31:0]             stat_lu_cnt,
  output logic [31:0]             stat_mdu_cnt,
`endif
  output logic [NREAD*SELW-1:0]   id_sel,
  output logic                    stall,
  output logic                    mdu_busy
);

  localparam int unsigned CW = $clog2(MDU_LAT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0]    sb_dst, sb_dst_nxt;

  logic [4:0] rd_addr [NREAD];
  logic       lu_hit;
  logic       raw_hit;
  logic       lu_stall;
  logic       mdu_stall;

  for (genvar p = 0; p < NREAD; p++) begin : g_addr
    assign rd_addr[p] = id_rd_addr[5*p +: 5];
  end

  // Source selects (nearest stage wins via descending scan) and per-port hazard matches
  always_comb begin
    id_sel  = '0;
    lu_hit  = 1'b0;
    raw_hit = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      if (rd_addr[p] != 5'd0) begin
        for (int s = STAGES - 1; s >= 0; s--) begin
          if (stage_regwr[s] && (stage_regdst[5*s +: 5] == rd_addr[p]))
            id_sel[SELW*p +: SELW] = SELW'(s + 1);
        end
      end
      if (id_rd_used[p] && (rd_addr[p] == stage_regdst[4:0]))
        lu_hit = 1'b1;
      if (id_rd_used[p] && (rd_addr[p] == sb_dst))
        raw_hit = 1'b1;
    end
  end

  // Stall terms; all gated by id_valid so bubbles never freeze the pipe
  always_comb begin
    lu_stall  = id_valid && ex_is_load && stage_regwr[0] &&
                (stage_regdst[4:0] != 5'd0) && lu_hit;
    mdu_stall = id_valid && mdu_busy &&
                (((sb_dst != 5'd0) && raw_hit) || id_is_mdu);
    stall     = lu_stall || mdu_stall;
  end

  // Scoreboard state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sb_dst <= 5'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sb_dst <= sb_dst_nxt;
    end
  end

  // Scoreboard next state; a start while BUSY is ignored
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sb_dst_nxt = sb_dst;
    case (state)
      IDLE: begin
        if (mdu_start) begin
          state_nxt  = BUSY;
          cnt_nxt    = CW'(MDU_LAT);
          sb_dst_nxt = mdu_dst;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scoreboard outputs
  always_comb begin
    mdu_busy = 1'b0;
    if (state == BUSY)
      mdu_busy = 1'b1;
  end

`ifdef FWD_HAZARD_STAT_EN
  // Stall statistics; clear has priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lu_cnt  <= 32'd0;
      stat_mdu_cnt <= 32'd0;
    end else if (stat_clr) begin
      stat_lu_cnt  <= 32'd0;
      stat_mdu_cnt <= 32'd0;
    end else begin
      if (lu_stall)
        stat_lu_cnt <= stat_lu_cnt + 32'd1;
      if (mdu_stall)
        stat_mdu_cnt <= stat_mdu_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (NREAD=2, STAGES=3, MDU_LAT=4).
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rd_addr;
  logic [1:0]  id_rd_used;
  logic        id_is_mdu;
  logic [2:0]  stage_regwr;
  logic [14:0] stage_regdst;
  logic        ex_is_load;
  logic        mdu_start;
  logic [4:0]  mdu_dst;
  logic [3:0]  id_sel;
  logic        stall;
  logic        mdu_busy;
  logic [4:0]  rs, rt;
`ifdef FWD_HAZARD_STAT_EN
  logic        stat_clr;
  logic [31:0] stat_lu_cnt;
  logic [31:0] stat_mdu_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int illegal_starts = 0;
  int model_cnt = 0;

  assign id_rd_addr = {rt, rs};

  fwd_hazard_unit #(.NREAD(2), .STAGES(3), .MDU_LAT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rd_addr   (id_rd_addr),
    .id_rd_used   (id_rd_used),
    .id_is_mdu    (id_is_mdu),
    .stage_regwr  (stage_regwr),
    .stage_regdst (stage_regdst),
    .ex_is_load   (ex_is_load),
    .mdu_start    (mdu_start),
    .mdu_dst      (mdu_dst),
`ifdef FWD_HAZARD_STAT_EN
    .stat_clr     (stat_clr),
    .stat_lu_cnt  (stat_lu_cnt),
    .stat_mdu_cnt (stat_mdu_cnt),
`endif
    .id_sel       (id_sel),
    .stall        (stall),
    .mdu_busy     (mdu_busy)
  );

  always #5 clk = ~clk;

  // Independent occupancy model; flags any MDU issue while the unit is occupied
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_cnt <= 0;
    end else if (model_cnt != 0) begin
      if (mdu_start) begin
        illegal_starts <= illegal_starts + 1;
        $display("note: illegal mdu_start while busy at %0t", $time);
      end
      model_cnt <= model_cnt - 1;
    end else if (mdu_start) begin
      model_cnt <= 4;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; rs = 5'd0; rt = 5'd0; id_rd_used = 2'b00;
    id_is_mdu = 1'b0; stage_regwr = 3'b000; stage_regdst = '0; ex_is_load = 1'b0;
    mdu_start = 1'b0; mdu_dst = 5'd0;
`ifdef FWD_HAZARD_STAT_EN
    stat_clr = 1'b0;
`endif
    tick(); tick();
    check("rst_busy", 32'(mdu_busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel", 32'(id_sel), 32'd0);
`ifdef FWD_HAZARD_STAT_EN
    check("rst_stat_lu", stat_lu_cnt, 32'd0);
    check("rst_stat_mdu", stat_mdu_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Forwarding priority: nearest stage first
    rs = 5'd5; rt = 5'd9; stage_regdst = {5'd5, 5'd5, 5'd5};
    stage_regwr = 3'b111; #1;
    check("prio_ex", 32'(id_sel[1:0]), 32'd1);
    check("prio_rt_none", 32'(id_sel[3:2]), 32'd0);
    stage_regwr = 3'b110; #1;
    check("prio_mem", 32'(id_sel[1:0]), 32'd2);
    stage_regwr = 3'b100; #1;
    check("prio_wr", 32'(id_sel[1:0]), 32'd3);
    stage_regwr = 3'b000; #1;
    check("prio_none", 32'(id_sel[1:0]), 32'd0);
    stage_regdst = {5'd9, 5'd7, 5'd5}; stage_regwr = 3'b111; #1;
    check("prio_rt_wr", 32'(id_sel[3:2]), 32'd3);

    // r0 is never forwarded and never stalls
    rs = 5'd0; rt = 5'd3; stage_regwr = 3'b001; stage_regdst = {5'd0, 5'd0, 5'd0};
    ex_is_load = 1'b1; id_valid = 1'b1; id_rd_used = 2'b11; #1;
    check("r0_sel", 32'(id_sel[1:0]), 32'd0);
    check("r0_stall", 32'(stall), 32'd0);

    // Load-use
    rs = 5'd4; rt = 5'd8; stage_regdst = {5'd0, 5'd0, 5'd8}; #1;
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_sel_rt", 32'(id_sel[3:2]), 32'd1);
    id_rd_used = 2'b01; #1;
    check("lu_unused", 32'(stall), 32'd0);
    check("lu_unused_sel", 32'(id_sel[3:2]), 32'd1);
    id_rd_used = 2'b11; id_valid = 1'b0; #1;
    check("lu_novalid", 32'(stall), 32'd0);
    id_valid = 1'b1; ex_is_load = 1'b0; #1;
    check("lu_noload", 32'(stall), 32'd0);

    // MDU timing: issue, busy for 4 cycles, r12 reader stalls, r13 does not
    stage_regwr = 3'b000; stage_regdst = '0; rs = 5'd12; rt = 5'd0;
    mdu_start = 1'b1; mdu_dst = 5'd12; #1;
    check("mdu_issue_busy", 32'(mdu_busy), 32'd0);
    check("mdu_issue_stall", 32'(stall), 32'd0);
    tick(); mdu_start = 1'b0; mdu_dst = 5'd0;
    for (int k = 1; k <= 4; k++) begin
      rs = 5'd12; #1;
      check($sformatf("mdu_busy_c%0d", k), 32'(mdu_busy), 32'd1);
      check($sformatf("mdu_raw_c%0d", k), 32'(stall), 32'd1);
      rs = 5'd13; #1;
      check($sformatf("mdu_r13_c%0d", k), 32'(stall), 32'd0);
      tick();
    end
    rs = 5'd12; #1;
    check("mdu_done_busy", 32'(mdu_busy), 32'd0);
    check("mdu_done_stall", 32'(stall), 32'd0);

    // Structural stall and illegal restart
    mdu_start = 1'b1; mdu_dst = 5'd12;
    tick(); mdu_start = 1'b0;
    rs = 5'd13; id_is_mdu = 1'b1; #1;
    check("struct_stall", 32'(stall), 32'd1);
    id_is_mdu = 1'b0; #1;
    check("struct_clear", 32'(stall), 32'd0);
    mdu_start = 1'b1; mdu_dst = 5'd20;
    tick(); mdu_start = 1'b0; mdu_dst = 5'd0;
    check("illegal_flagged", 32'(illegal_starts), 32'd1);
    rs = 5'd20; #1;
    check("illegal_dst_kept", 32'(stall), 32'd0);
    rs = 5'd12; #1;
    check("illegal_orig_dst", 32'(stall), 32'd1);
    tick();
    check("illegal_c3_busy", 32'(mdu_busy), 32'd1);
    tick();
    check("illegal_c4_busy", 32'(mdu_busy), 32'd1);
    tick();
    check("illegal_cnt_kept", 32'(mdu_busy), 32'd0);

    // Asynchronous reset mid-BUSY
    mdu_start = 1'b1; mdu_dst = 5'd12;
    tick(); mdu_start = 1'b0;
    tick();
    check("rst_pre_busy", 32'(mdu_busy), 32'd1);
    #2 rst_n = 1'b0; #1;
    check("rst_async_busy", 32'(mdu_busy), 32'd0);
    check("rst_async_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_after_busy", 32'(mdu_busy), 32'd0);
    check("rst_after_stall", 32'(stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
